// File: rtl/spisr.sv
// SPI status register: one 8-bit register with a load enable, write mask and
// synchronous reset. The flag outputs are taken straight from the register bits.
module spisr #(
  parameter logic [7:0] RESET_VAL = 8'h20,
  parameter logic [7:0] WMASK     = 8'hB0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] SPISR_in,
  output logic       SPIF,
  output logic       SPTEF,
  output logic       MODF,
  output logic [7:0] SPISR_out
);

  localparam int unsigned REG_W     = 8;
  localparam int unsigned SPIF_BIT  = 7;
  localparam int unsigned SPTEF_BIT = 5;
  localparam int unsigned MODF_BIT  = 4;

  logic [REG_W-1:0] status_q;

  // Reset wins over a load. Unimplemented bits are masked off on every load.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= RESET_VAL;
    end else if (en) begin
      status_q <= SPISR_in & WMASK;
    end
  end

  assign SPISR_out = status_q;
  assign SPIF      = status_q[SPIF_BIT];
  assign SPTEF     = status_q[SPTEF_BIT];
  assign MODF      = status_q[MODF_BIT];

endmodule

// File: tb/tb_spisr.sv
// Directed plus random checks of spisr. Expected register values are queued
// when a step is driven and popped once the sampled edge has taken effect.
module tb_spisr;

  localparam logic [7:0] RST_V = 8'h20;
  localparam logic [7:0] MASK  = 8'hB0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] spisr_in;
  logic       spif;
  logic       sptef;
  logic       modf;
  logic [7:0] spisr_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  sb[$];
  logic [7:0]  model;

  spisr dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .SPISR_in  (spisr_in),
    .SPIF      (spif),
    .SPTEF     (sptef),
    .MODF      (modf),
    .SPISR_out (spisr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against one expected register value.
  task automatic check_all(input string tag, input logic [7:0] exp);
    check({tag, ".out"},    spisr_out, exp);
    check({tag, ".spif"},   8'(spif),  8'(exp[7]));
    check({tag, ".sptef"},  8'(sptef), 8'(exp[5]));
    check({tag, ".modf"},   8'(modf),  8'(exp[4]));
    check({tag, ".unimpl"}, spisr_out & ~MASK, 8'h00);
  endtask

  // Drive inputs on the falling edge, push the expected value, sample after the rising edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [7:0] d, input logic [7:0] exp);
    logic [7:0] want;
    @(negedge clk);
    rst = r;
    en = e;
    spisr_in = d;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, spisr_out);
    end else begin
      want = sb.pop_front();
      check_all(tag, want);
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    spisr_in = 8'h00;
    repeat (2) @(posedge clk);

    step("rst_with_en", 1'b1, 1'b1, 8'b1001_1110, 8'h20);
    step("load_9e",     1'b0, 1'b1, 8'b1001_1110, 8'h90);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 8'b0011_1010, 8'h90);
    step("load_3a",     1'b0, 1'b1, 8'b0011_1010, 8'h30);

    // Inputs and reset toggled between edges must not disturb the outputs.
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    spisr_in = 8'hFF;
    #2;
    check_all("mid_rst", 8'h30);
    rst = 1'b0;
    en = 1'b0;
    #1;
    check_all("mid_rst_rel", 8'h30);
    step("after_pulse", 1'b0, 1'b0, 8'hFF, 8'h30);
    step("rst_held",    1'b1, 1'b0, 8'hFF, RST_V);

    step("ff_a",  1'b0, 1'b1, 8'hFF, 8'hB0);
    step("ff_b",  1'b0, 1'b1, 8'hFF, 8'hB0);
    step("zero",  1'b0, 1'b1, 8'h00, 8'h00);
    step("b2b_1", 1'b0, 1'b1, 8'h10, 8'h10);
    step("b2b_2", 1'b0, 1'b1, 8'h80, 8'h80);
    step("midop_rst", 1'b1, 1'b1, 8'h90, RST_V);

    model = RST_V;
    for (int i = 0; i < 40; i++) begin
      logic       r;
      logic       e;
      logic [7:0] d;
      r = ($urandom_range(0, 7) == 0);
      e = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (r)      model = RST_V;
      else if (e) model = d & MASK;
      step("rand", r, e, d, model);
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
